pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage in-order pipeline (IF, DE, EX, MEM, WB).
- Merges hazard sources into one prioritised set of per-latch hold/squash controls and a next-PC select:
  - load-use stall from the forwarding unit
  - I-cache and D-cache busy
  - multicycle EX unit busy
  - branch redirect
  - MEM-stage trap
- Owns a small FSM that discards a stale I-cache miss after a redirect, plus saturating performance counters.

---
 rtl/pipeline_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/flush sequencer for a 5-stage in-order pipeline.
//               Merges hazard sources into prioritised per-latch hold and
//               squash controls plus a next-PC select. A two-state FSM drops
//               a stale I-cache response after a redirect. Saturating
//               counters track stalled-fetch cycles and flush events.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_stall,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             ex_busy,
    input  logic             ex_redirect,
    input  logic             mem_trap,
    output logic             if_stall,
    output logic             de_stall,
    output logic             ex_stall,
    output logic             mem_stall,
    output logic             de_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             wb_flush,
    output logic [1:0]       pc_sel,
    output logic             if_discard,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [1:0]       c_PC_SEQ   = 2'd0;
    localparam logic [1:0]       c_PC_REDIR = 2'd1;
    localparam logic [1:0]       c_PC_TRAP  = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        S_RUN     = 1'b0,
        S_DISCARD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_event;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    // Hazard priority resolution and next-state selection
    always_comb begin
        if_stall     = 1'b0;
        de_stall     = 1'b0;
        ex_stall     = 1'b0;
        mem_stall    = 1'b0;
        de_flush     = 1'b0;
        ex_flush     = 1'b0;
        mem_flush    = 1'b0;
        wb_flush     = 1'b0;
        pc_sel       = c_PC_SEQ;
        if_discard   = 1'b0;
        w_event      = 1'b0;
        w_next_state = r_state;

        if (reset) begin
            // Every pipeline latch is invalidated while reset is held
            de_flush     = 1'b1;
            ex_flush     = 1'b1;
            mem_flush    = 1'b1;
            wb_flush     = 1'b1;
            w_next_state = S_RUN;
        end else begin
            // While discarding, fetch is held and the stale response dropped;
            // the later-stage rules below are merged on top of this.
            if (r_state == S_DISCARD) begin
                if_discard = 1'b1;
                de_flush   = 1'b1;
                if_stall   = 1'b1;
            end

            if (mem_busy) begin
                // D-cache miss freezes everything; trap/redirect must wait
                if_stall  = 1'b1;
                de_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_stall = 1'b1;
                wb_flush  = 1'b1;
            end else if (mem_trap) begin
                de_flush  = 1'b1;
                ex_flush  = 1'b1;
                mem_flush = 1'b1;
                pc_sel    = c_PC_TRAP;
                w_event   = 1'b1;
            end else if (ex_busy) begin
                // A redirect from an unfinished EX op is not yet valid
                if_stall  = 1'b1;
                de_stall  = 1'b1;
                ex_stall  = 1'b1;
                mem_flush = 1'b1;
            end else if (ex_redirect) begin
                de_flush  = 1'b1;
                ex_flush  = 1'b1;
                pc_sel    = c_PC_REDIR;
                w_event   = 1'b1;
            end else if (load_stall) begin
                if_stall  = 1'b1;
                de_stall  = 1'b1;
                ex_flush  = 1'b1;
            end else if (if_busy) begin
                if_stall  = 1'b1;
                de_flush  = 1'b1;
            end

            // A redirect during an outstanding miss leaves a stale response
            // in flight. In DISCARD a new redirect keeps us there; otherwise
            // the cycle where if_busy is low drops the response and exits.
            if (r_state == S_RUN) begin
                w_next_state = (w_event && if_busy) ? S_DISCARD : S_RUN;
            end else begin
                w_next_state = (w_event || if_busy) ? S_DISCARD : S_RUN;
            end
        end
    end

    // FSM state and saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_RUN;
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            r_state <= w_next_state;
            if (if_stall && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            end
            if (w_event && (r_flush_events != c_CNT_MAX)) begin
                r_flush_events <= r_flush_events + c_CNT_ONE;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Self-checking bench for pipeline_ctrl. Two instances (32-bit
//               and 4-bit counters) share stimulus; a rule-level reference
//               model predicts controls and unbounded event counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    // Input vector order: {load_stall, if_busy, mem_busy, ex_busy, ex_redirect, mem_trap}
    localparam logic [5:0] LS = 6'b100000;
    localparam logic [5:0] IB = 6'b010000;
    localparam logic [5:0] MB = 6'b001000;
    localparam logic [5:0] EB = 6'b000100;
    localparam logic [5:0] ER = 6'b000010;
    localparam logic [5:0] MT = 6'b000001;

    // Control vector order: {if,de,ex,mem stall, de,ex,mem,wb flush, pc_sel[1:0], if_discard}
    localparam logic [10:0] O_RESET  = 11'b0000_1111_00_0;
    localparam logic [10:0] O_FREEZE = 11'b1111_0001_00_0;
    localparam logic [10:0] O_TRAP   = 11'b0000_1110_10_0;
    localparam logic [10:0] O_EXBUSY = 11'b1110_0010_00_0;
    localparam logic [10:0] O_REDIR  = 11'b0000_1100_01_0;
    localparam logic [10:0] O_LOAD   = 11'b1100_0100_00_0;
    localparam logic [10:0] O_IBUSY  = 11'b1000_1000_00_0;

    logic clk = 1'b0;
    logic reset, load_stall, if_busy, mem_busy, ex_busy, ex_redirect, mem_trap;

    logic a_if_stall, a_de_stall, a_ex_stall, a_mem_stall;
    logic a_de_flush, a_ex_flush, a_mem_flush, a_wb_flush, a_if_discard;
    logic [1:0]  a_pc_sel;
    logic [31:0] a_stall_cycles, a_flush_events;

    logic b_if_stall, b_de_stall, b_ex_stall, b_mem_stall;
    logic b_de_flush, b_ex_flush, b_mem_flush, b_wb_flush, b_if_discard;
    logic [1:0]  b_pc_sel;
    logic [3:0]  b_stall_cycles, b_flush_events;

    logic [10:0] a_vec, b_vec;
    assign a_vec = {a_if_stall, a_de_stall, a_ex_stall, a_mem_stall,
                    a_de_flush, a_ex_flush, a_mem_flush, a_wb_flush, a_pc_sel, a_if_discard};
    assign b_vec = {b_if_stall, b_de_stall, b_ex_stall, b_mem_stall,
                    b_de_flush, b_ex_flush, b_mem_flush, b_wb_flush, b_pc_sel, b_if_discard};

    pipeline_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .load_stall(load_stall), .if_busy(if_busy),
        .mem_busy(mem_busy), .ex_busy(ex_busy), .ex_redirect(ex_redirect), .mem_trap(mem_trap),
        .if_stall(a_if_stall), .de_stall(a_de_stall), .ex_stall(a_ex_stall), .mem_stall(a_mem_stall),
        .de_flush(a_de_flush), .ex_flush(a_ex_flush), .mem_flush(a_mem_flush), .wb_flush(a_wb_flush),
        .pc_sel(a_pc_sel), .if_discard(a_if_discard),
        .stall_cycles(a_stall_cycles), .flush_events(a_flush_events)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut_w4 (
        .clk(clk), .reset(reset), .load_stall(load_stall), .if_busy(if_busy),
        .mem_busy(mem_busy), .ex_busy(ex_busy), .ex_redirect(ex_redirect), .mem_trap(mem_trap),
        .if_stall(b_if_stall), .de_stall(b_de_stall), .ex_stall(b_ex_stall), .mem_stall(b_mem_stall),
        .de_flush(b_de_flush), .ex_flush(b_ex_flush), .mem_flush(b_mem_flush), .wb_flush(b_wb_flush),
        .pc_sel(b_pc_sel), .if_discard(b_if_discard),
        .stall_cycles(b_stall_cycles), .flush_events(b_flush_events)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: discard mode flag and unbounded event counts
    bit              m_disc;
    longint unsigned m_stall;
    longint unsigned m_flush;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint unsigned sat(input longint unsigned v, input int w);
        longint unsigned mx;
        mx = (64'd1 << w) - 64'd1;
        return (v > mx) ? mx : v;
    endfunction

    // Rule-level model: pick the winning hazard, look up its control pattern,
    // then merge in the discard-mode controls.
    function automatic logic [10:0] model_out(input logic [5:0] in, input bit rst, input bit disc,
                                              output bit ev, output bit nd);
        int          rule;
        logic [10:0] o;
        ev = 1'b0;
        nd = 1'b0;
        if (rst) return O_RESET;
        if      (in[3]) rule = 1;
        else if (in[0]) rule = 2;
        else if (in[2]) rule = 3;
        else if (in[1]) rule = 4;
        else if (in[5]) rule = 5;
        else if (in[4]) rule = 6;
        else            rule = 7;
        case (rule)
            1:       o = O_FREEZE;
            2:       o = O_TRAP;
            3:       o = O_EXBUSY;
            4:       o = O_REDIR;
            5:       o = O_LOAD;
            6:       o = O_IBUSY;
            default: o = 11'b0;
        endcase
        if (disc) o = o | 11'b1000_1000_00_1;
        ev = (rule == 2) || (rule == 4);
        nd = disc ? (ev || in[4]) : (ev && in[4]);
        return o;
    endfunction

    // One clock: apply inputs, check controls mid-cycle, advance model, check counters
    task automatic cycle(input logic [5:0] in, input bit rst, output logic [10:0] got);
        logic [10:0] exp;
        bit ev, nd;
        {load_stall, if_busy, mem_busy, ex_busy, ex_redirect, mem_trap} = in;
        reset = rst;
        @(negedge clk);
        exp = model_out(in, rst, m_disc, ev, nd);
        got = a_vec;
        chk("ctrl", {53'd0, a_vec}, {53'd0, exp});
        chk("ctrl_w4", {53'd0, b_vec}, {53'd0, exp});
        if (rst) begin
            m_disc  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (exp[10]) m_stall++;
            if (ev) m_flush++;
            m_disc = nd;
        end
        @(posedge clk);
        #1;
        chk("stall_cycles", {32'd0, a_stall_cycles}, sat(m_stall, 32));
        chk("flush_events", {32'd0, a_flush_events}, sat(m_flush, 32));
        chk("stall_cycles_w4", {60'd0, b_stall_cycles}, sat(m_stall, 4));
        chk("flush_events_w4", {60'd0, b_flush_events}, sat(m_flush, 4));
    endtask

    typedef struct {
        logic [5:0]  in;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] got;

    initial begin
        int          n;
        logic [31:0] s0, f0;
        logic [5:0]  rin;
        bit          rrst;

        m_disc = 1'b0; m_stall = 0; m_flush = 0;
        {load_stall, if_busy, mem_busy, ex_busy, ex_redirect, mem_trap} = 6'b0;
        reset = 1'b1;

        // Single-cycle priority table, all applied from RUN
        vecs.push_back('{6'b0,                  11'b0,    "idle"});
        vecs.push_back('{LS,                    O_LOAD,   "load_stall"});
        vecs.push_back('{IB,                    O_IBUSY,  "if_busy"});
        vecs.push_back('{LS|IB|MB|EB|ER|MT,     O_FREEZE, "mem_busy_all"});
        vecs.push_back('{MT,                    O_TRAP,   "trap"});
        vecs.push_back('{MT|ER,                 O_TRAP,   "trap_over_redir"});
        vecs.push_back('{EB|ER,                 O_EXBUSY, "exbusy_over_redir"});
        vecs.push_back('{ER|LS,                 O_REDIR,  "redir_over_load"});
        vecs.push_back('{LS|IB,                 O_LOAD,   "load_over_ibusy"});
        vecs.push_back('{EB|LS,                 O_EXBUSY, "exbusy_over_load"});

        // Reset held two cycles, then release
        cycle(6'b0, 1'b1, got); chk("reset_ctrl0", {53'd0, got}, {53'd0, O_RESET});
        cycle(6'b0, 1'b1, got); chk("reset_ctrl1", {53'd0, got}, {53'd0, O_RESET});
        chk("reset_cnt", {32'd0, a_stall_cycles}, 64'd0);
        cycle(6'b0, 1'b0, got); chk("after_reset", {53'd0, got}, 64'd0);

        foreach (vecs[i]) begin
            cycle(vecs[i].in, 1'b0, got);
            chk(vecs[i].name, {53'd0, got}, {53'd0, vecs[i].exp});
        end

        // Load-use stall for one cycle counts one stall cycle
        s0 = a_stall_cycles;
        cycle(LS, 1'b0, got);    chk("ls_one", {53'd0, got}, {53'd0, O_LOAD});
        cycle(6'b0, 1'b0, got);  chk("ls_gone", {53'd0, got}, 64'd0);
        chk("ls_count", {32'd0, a_stall_cycles - s0}, 64'd1);

        // Redirect during I-cache miss: four discard cycles, one event
        f0 = a_flush_events;
        n  = 0;
        cycle(ER|IB, 1'b0, got); chk("redir_miss", {53'd0, got}, {53'd0, O_REDIR});
        for (int k = 0; k < 3; k++) begin
            cycle(IB, 1'b0, got);
            if (got[0]) n++;
        end
        cycle(6'b0, 1'b0, got);
        if (got[0]) n++;
        chk("discard_last", {53'd0, got}, {53'd0, 11'b1000_1000_00_1});
        chk("discard_cycles", n, 4);
        cycle(6'b0, 1'b0, got);  chk("back_to_run", {53'd0, got}, 64'd0);
        chk("redir_events", {32'd0, a_flush_events - f0}, 64'd1);

        // Freeze holds a pending trap and redirect, then the trap wins
        f0 = a_flush_events;
        n  = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(MB|MT|ER, 1'b0, got);
            if (got == O_FREEZE) n++;
        end
        chk("freeze_cycles", n, 5);
        cycle(MT|ER, 1'b0, got); chk("trap_after_freeze", {53'd0, got}, {53'd0, O_TRAP});
        chk("trap_events", {32'd0, a_flush_events - f0}, 64'd1);

        // Redirect is ignored while EX is busy
        cycle(EB|ER, 1'b0, got); chk("exbusy_c1", {53'd0, got}, {53'd0, O_EXBUSY});
        cycle(EB|ER, 1'b0, got); chk("exbusy_c2", {53'd0, got}, {53'd0, O_EXBUSY});
        cycle(ER, 1'b0, got);    chk("exbusy_c3", {53'd0, got}, {53'd0, O_REDIR});

        // Counter saturation on the 4-bit instance
        cycle(6'b0, 1'b1, got);
        for (int k = 0; k < 20; k++) cycle(IB, 1'b0, got);
        chk("sat_w4", {60'd0, b_stall_cycles}, 64'd15);
        chk("nosat_w32", {32'd0, a_stall_cycles}, 64'd20);

        // Randomised traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            rin[5] = ($urandom_range(0, 99) < 15);
            rin[4] = ($urandom_range(0, 99) < 45);
            rin[3] = ($urandom_range(0, 99) < 10);
            rin[2] = ($urandom_range(0, 99) < 15);
            rin[1] = ($urandom_range(0, 99) < 15);
            rin[0] = ($urandom_range(0, 99) < 10);
            rrst   = ($urandom_range(0, 199) == 0);
            cycle(rin, rrst, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
